// File: rtl/tnoc_vc_buffered_demux.sv
// rtl/tnoc_vc_buffered_demux.sv - buffered per-VC demux with FWFT FIFOs, registered availability and sticky multi-hot error
module tnoc_vc_buffered_demux #(
    parameter int CHANNELS     = 2,
    parameter int FLIT_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter int AVAIL_MARGIN = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [CHANNELS-1:0]            i_valid,
    output logic [CHANNELS-1:0]            o_ready,
    input  logic [FLIT_WIDTH-1:0]          i_flit,
    output logic [CHANNELS-1:0]            o_vc_available,
    output logic [CHANNELS-1:0]            o_valid,
    input  logic [CHANNELS-1:0]            i_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit,
    input  logic [CHANNELS-1:0]            i_vc_available,
    output logic                           o_protocol_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(AVAIL_MARGIN);

    logic [FLIT_WIDTH-1:0] mem [CHANNELS][DEPTH];
    logic [PW-1:0]         wr_ptr [CHANNELS];
    logic [PW-1:0]         rd_ptr [CHANNELS];
    logic [CW-1:0]         count [CHANNELS];
    logic [CW-1:0]         count_next [CHANNELS];

    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] blocked;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] avail_next;
    logic                multi_hot;
    logic                seen;

    // Lowest-index valid wins; every higher VC is masked off that cycle.
    always_comb begin
        full       = '0;
        empty      = '0;
        blocked    = '0;
        o_ready    = '0;
        push       = '0;
        o_valid    = '0;
        pop        = '0;
        avail_next = '0;
        count_next = count;
        seen       = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            full[i]    = (count[i] == DEPTH_C);
            empty[i]   = (count[i] == '0);
            blocked[i] = seen;
            seen       = seen | i_valid[i];
            o_ready[i] = !full[i] && !blocked[i];
            push[i]    = i_valid[i] && o_ready[i];
            o_valid[i] = !empty[i];
            pop[i]     = o_valid[i] && i_ready[i];
            if (push[i] && !pop[i]) begin
                count_next[i] = count[i] + CW'(1);
            end else if (pop[i] && !push[i]) begin
                count_next[i] = count[i] - CW'(1);
            end
            avail_next[i] = i_vc_available[i] && ((DEPTH_C - count_next[i]) >= MARGIN_C);
        end
    end

    assign multi_hot = ((i_valid & (i_valid - CHANNELS'(1))) != '0);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_head
        assign o_flit[g*FLIT_WIDTH +: FLIT_WIDTH] = mem[g][rd_ptr[g]];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            o_vc_available   <= '0;
            o_protocol_error <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                count[i] <= count_next[i];
            end
            o_vc_available <= avail_next;
            if (multi_hot) begin
                o_protocol_error <= 1'b1;
            end
        end
    end

    // Storage is left unreset; count gating makes stale entries invisible.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= i_flit;
            end
        end
    end

endmodule

// File: tb/tb_tnoc_vc_buffered_demux.sv
// tb/tb_tnoc_vc_buffered_demux.sv - randomized scoreboard bench for tnoc_vc_buffered_demux
module tb_tnoc_vc_buffered_demux;

    localparam int CH     = 2;
    localparam int FW     = 64;
    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    logic              i_clk;
    logic              i_rst;
    logic [CH-1:0]     i_valid;
    logic [CH-1:0]     o_ready;
    logic [FW-1:0]     i_flit;
    logic [CH-1:0]     o_vc_available;
    logic [CH-1:0]     o_valid;
    logic [CH-1:0]     i_ready;
    logic [CH*FW-1:0]  o_flit;
    logic [CH-1:0]     i_vc_available;
    logic              o_protocol_error;

    tnoc_vc_buffered_demux #(
        .CHANNELS    (CH),
        .FLIT_WIDTH  (FW),
        .DEPTH       (DEPTH),
        .AVAIL_MARGIN(MARGIN)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_flit          (i_flit),
        .o_vc_available  (o_vc_available),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_flit          (o_flit),
        .i_vc_available  (i_vc_available),
        .o_protocol_error(o_protocol_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] sb_q [CH][$];
    logic [CH-1:0] m_avail;
    logic          m_err;
    bit            model_ok = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    // Monitor compares DUT outputs with the queue model, then advances the model for the next edge.
    always @(negedge i_clk) begin
        int            pre_size [CH];
        logic [CH-1:0] exp_ready;
        logic [CH-1:0] exp_valid;
        int            winner;
        for (int i = 0; i < CH; i++) pre_size[i] = sb_q[i].size();
        if (model_ok) begin
            for (int i = 0; i < CH; i++) begin
                exp_ready[i] = (pre_size[i] < DEPTH) && ((int'(i_valid) % (1 << i)) == 0);
                exp_valid[i] = (pre_size[i] != 0);
            end
            check("ready", FW'(o_ready), FW'(exp_ready));
            check("valid", FW'(o_valid), FW'(exp_valid));
            check("vc_available", FW'(o_vc_available), FW'(m_avail));
            check("protocol_error", FW'(o_protocol_error), FW'(m_err));
            for (int i = 0; i < CH; i++) begin
                if (pre_size[i] != 0) check($sformatf("flit_vc%0d", i), o_flit[i*FW +: FW], sb_q[i][0]);
            end
        end
        if (i_rst) begin
            for (int i = 0; i < CH; i++) sb_q[i].delete();
            m_avail  = '0;
            m_err    = 1'b0;
            model_ok = 1;
        end else if (model_ok) begin
            winner = -1;
            for (int i = CH - 1; i >= 0; i--) if (i_valid[i]) winner = i;
            for (int i = 0; i < CH; i++) if (pre_size[i] != 0 && i_ready[i]) void'(sb_q[i].pop_front());
            if (winner >= 0 && pre_size[winner] < DEPTH) sb_q[winner].push_back(i_flit);
            for (int i = 0; i < CH; i++)
                m_avail[i] = i_vc_available[i] && ((DEPTH - sb_q[i].size()) >= MARGIN);
            if ($countones(i_valid) > 1) m_err = 1'b1;
        end
    end

    task automatic step(input logic [CH-1:0] v, input logic [FW-1:0] f,
                        input logic [CH-1:0] r, input logic [CH-1:0] a);
        i_valid        = v;
        i_flit         = f;
        i_ready        = r;
        i_vc_available = a;
        @(posedge i_clk);
        #1;
    endtask

    task automatic random_cycles(input int n);
        int            sel;
        logic [CH-1:0] v;
        logic [CH-1:0] a;
        for (int k = 0; k < n; k++) begin
            sel = $urandom_range(0, 9);
            v = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            for (int i = 0; i < CH; i++) a[i] = ($urandom_range(0, 7) != 0);
            step(v, {$urandom, $urandom}, CH'($urandom_range(0, 3)), a);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        step(2'b00, 64'h0, 2'b00, 2'b11);
        step(2'b00, 64'h0, 2'b00, 2'b11);
        step(2'b00, 64'h0, 2'b00, 2'b11);
        i_rst = 1'b0;
        step(2'b10, 64'hA5, 2'b00, 2'b11);
        step(2'b00, 64'h0, 2'b00, 2'b11);
        step(2'b00, 64'h0, 2'b10, 2'b11);
        for (int k = 1; k <= 5; k++) step(2'b01, FW'(k), 2'b00, 2'b11);
        step(2'b01, 64'd5, 2'b00, 2'b11);
        step(2'b01, 64'd5, 2'b00, 2'b10);
        for (int k = 0; k < 3; k++) step(2'b01, 64'd5, 2'b01, 2'b11);
        for (int k = 0; k < 5; k++) step(2'b00, 64'h0, 2'b01, 2'b11);
        step(2'b10, 64'h100, 2'b00, 2'b11);
        for (int k = 1; k <= 20; k++) step(2'b10, 64'h100 + FW'(k), 2'b10, 2'b11);
        step(2'b00, 64'h0, 2'b10, 2'b11);
        step(2'b11, 64'hC3, 2'b00, 2'b11);
        step(2'b00, 64'h0, 2'b11, 2'b11);
        random_cycles(300);
        for (int k = 0; k < 6; k++) step(2'b00, 64'h0, 2'b11, 2'b11);
        for (int k = 0; k < 3; k++) step(2'b01, 64'h200 + FW'(k), 2'b00, 2'b11);
        for (int k = 0; k < 3; k++) step(2'b10, 64'h300 + FW'(k), 2'b00, 2'b11);
        i_rst = 1'b1;
        step(2'b11, 64'hDEAD, 2'b11, 2'b11);
        i_rst = 1'b0;
        step(2'b00, 64'h0, 2'b11, 2'b11);
        step(2'b00, 64'h0, 2'b11, 2'b01);
        random_cycles(300);
        i_rst = 1'b1;
        step(2'b00, 64'h0, 2'b00, 2'b11);
        i_rst = 1'b0;
        random_cycles(100);
        @(negedge i_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
